// File: rtl/spi_pattern_slave.sv
// SPI slave that oversamples the MCU pins in the clk_50mhz domain and streams generated words.
// The pattern source is counter, LFSR, constant or loopback. MOSI words are captured and counted.
module spi_pattern_slave #(
    parameter int unsigned       WORD_W    = 8,
    parameter int unsigned       CNT_W     = 16,
    parameter bit                CPOL      = 1'b0,
    parameter logic [WORD_W-1:0] LFSR_TAPS = WORD_W'(8'hB8),
    parameter logic [WORD_W-1:0] LFSR_SEED = WORD_W'(8'h01)
) (
    input  logic              clk_50mhz,
    input  logic              rst_n,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [1:0]        pattern_sel,
    input  logic [WORD_W-1:0] const_word,
    output logic [WORD_W-1:0] rx_word,
    output logic              rx_valid,
    output logic [CNT_W-1:0]  word_cnt
);

    localparam int unsigned       BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        PAT_COUNTER  = 2'b00,
        PAT_LFSR     = 2'b01,
        PAT_CONST    = 2'b10,
        PAT_LOOPBACK = 2'b11
    } pattern_e;

    // Index 0 is the pin-facing flop, index 1 is the synced value, index 2 is the edge-detect history.
    logic [2:0]        r_sck_sync;
    logic [2:0]        r_cs_sync;
    logic [1:0]        r_mosi_sync;

    logic [BIT_W-1:0]  r_bit_cnt;
    logic [WORD_W-1:0] r_tx_shift;
    logic [WORD_W-2:0] r_rx_shift;
    logic [WORD_W-1:0] r_lfsr;
    logic [WORD_W-1:0] r_rx_word;
    logic              r_rx_valid;
    logic [CNT_W-1:0]  r_word_cnt;

    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_lead_edge;
    logic              w_trail_edge;
    logic              w_cs_fall;
    logic              w_cs_rise;
    logic              w_cs_active;
    logic [WORD_W-1:0] w_rx_next;
    logic [WORD_W-1:0] w_lfsr_next;
    logic [WORD_W-1:0] w_cnt_word;
    logic [WORD_W-1:0] w_gen_word;
    pattern_e          w_pattern;

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= {3{CPOL}};
            r_cs_sync   <= 3'b111;
            r_mosi_sync <= '0;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], spi_clk};
            r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
        end
    end

    assign w_sck_rise   =  r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall   = ~r_sck_sync[1] &  r_sck_sync[2];
    assign w_lead_edge  = CPOL ? w_sck_fall : w_sck_rise;
    assign w_trail_edge = CPOL ? w_sck_rise : w_sck_fall;
    assign w_cs_fall    = ~r_cs_sync[1] &  r_cs_sync[2];
    assign w_cs_rise    =  r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cs_active  = ~r_cs_sync[1];

    assign w_rx_next   = {r_rx_shift, r_mosi_sync[1]};
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_TAPS) : (r_lfsr >> 1);

    generate
        if (CNT_W >= WORD_W) begin : g_cnt_trunc
            assign w_cnt_word = r_word_cnt[WORD_W-1:0];
        end else begin : g_cnt_ext
            assign w_cnt_word = {{(WORD_W - CNT_W){1'b0}}, r_word_cnt};
        end
    endgenerate

    assign w_pattern = pattern_e'(pattern_sel);

    // NOTE: the default assignment ahead of the case keeps this block free of inferred latches.
    always_comb begin
        w_gen_word = '0;
        unique case (w_pattern)
            PAT_COUNTER:  w_gen_word = w_cnt_word;
            PAT_LFSR:     w_gen_word = r_lfsr;
            PAT_CONST:    w_gen_word = const_word;
            PAT_LOOPBACK: w_gen_word = r_rx_word;
            default:      w_gen_word = '0;
        endcase
    end

    // CS edges take priority over any SCK edge seen in the same cycle.
    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_lfsr     <= LFSR_SEED;
            r_rx_word  <= '0;
            r_rx_valid <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_cs_fall) begin
                r_bit_cnt  <= '0;
                r_tx_shift <= w_gen_word;
                r_rx_shift <= '0;
            end else if (w_cs_rise) begin
                r_bit_cnt <= '0;
            end else if (w_cs_active) begin
                if (w_lead_edge) begin
                    r_rx_shift <= w_rx_next[WORD_W-2:0];
                    if (r_bit_cnt == LAST_BIT) begin
                        r_rx_word  <= w_rx_next;
                        r_rx_valid <= 1'b1;
                        r_word_cnt <= r_word_cnt + CNT_W'(1);
                        r_lfsr     <= w_lfsr_next;
                        r_bit_cnt  <= '0;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end
                end else if (w_trail_edge) begin
                    // Bit counter at zero on a trailing edge means the previous word just completed.
                    if (r_bit_cnt == '0) begin
                        r_tx_shift <= w_gen_word;
                    end else begin
                        r_tx_shift <= {r_tx_shift[WORD_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_miso_oe = ~r_cs_sync[2];
    assign spi_miso    = r_tx_shift[WORD_W-1] & spi_miso_oe;
    assign rx_word     = r_rx_word;
    assign rx_valid    = r_rx_valid;
    assign word_cnt    = r_word_cnt;

endmodule

// File: tb/tb_spi_pattern_slave.sv
// Bench for spi_pattern_slave: a CPOL=0 instance and a CPOL=1/CNT_W=4 instance,
// driven by an MCU-style SPI master and compared against a word-level reference model.
module tb_spi_pattern_slave;

    localparam int W    = 8;
    localparam int HALF = 6;

    logic clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    logic         rst_n;
    logic [1:0]   sck;
    logic [1:0]   cs_n;
    logic [1:0]   mosi;
    logic [1:0]   psel  [2];
    logic [W-1:0] cword [2];

    wire  [1:0]   miso;
    wire  [1:0]   oe;
    wire  [1:0]   rxv;
    wire  [W-1:0] rxw0;
    wire  [W-1:0] rxw1;
    wire  [15:0]  wc0;
    wire  [3:0]   wc1;

    spi_pattern_slave #(.WORD_W(W), .CNT_W(16), .CPOL(1'b0)) dut0 (
        .clk_50mhz   (clk_50mhz),
        .rst_n       (rst_n),
        .spi_clk     (sck[0]),
        .spi_cs_n    (cs_n[0]),
        .spi_mosi    (mosi[0]),
        .spi_miso    (miso[0]),
        .spi_miso_oe (oe[0]),
        .pattern_sel (psel[0]),
        .const_word  (cword[0]),
        .rx_word     (rxw0),
        .rx_valid    (rxv[0]),
        .word_cnt    (wc0)
    );

    spi_pattern_slave #(.WORD_W(W), .CNT_W(4), .CPOL(1'b1)) dut1 (
        .clk_50mhz   (clk_50mhz),
        .rst_n       (rst_n),
        .spi_clk     (sck[1]),
        .spi_cs_n    (cs_n[1]),
        .spi_mosi    (mosi[1]),
        .spi_miso    (miso[1]),
        .spi_miso_oe (oe[1]),
        .pattern_sel (psel[1]),
        .const_word  (cword[1]),
        .rx_word     (rxw1),
        .rx_valid    (rxv[1]),
        .word_cnt    (wc1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: word-level state, advanced once per completed word.
    int           m_cnt   [2];
    logic [W-1:0] m_lfsr  [2];
    logic [W-1:0] m_rx    [2];
    int           cnt_mod [2] = '{65536, 16};
    logic [W-1:0] mo_q [$];

    int rv_cnt [2] = '{0, 0};
    always @(negedge clk_50mhz) begin
        if (rxv[0]) rv_cnt[0]++;
        if (rxv[1]) rv_cnt[1]++;
    end

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    function automatic logic [W-1:0] gen_word(input int d);
        case (psel[d])
            2'd0:    return W'(m_cnt[d]);
            2'd1:    return m_lfsr[d];
            2'd2:    return cword[d];
            default: return m_rx[d];
        endcase
    endfunction

    function automatic logic [W-1:0] rx_of(input int d);
        return (d == 0) ? rxw0 : rxw1;
    endfunction

    function automatic logic [31:0] wc_of(input int d);
        return (d == 0) ? 32'(wc0) : 32'(wc1);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_lfsr[d] = 8'h01;
            m_rx[d]   = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_50mhz);
        rst_n = 1'b0;
        sck   = 2'b10;
        cs_n  = 2'b11;
        mosi  = 2'b00;
        wait_clk(2);
        rst_n = 1'b1;
        model_reset();
        wait_clk(4);
    endtask

    // One CS-framed transfer of nwords full words, optionally followed by abort_bits of a partial word.
    task automatic xfer(input int d, input int nwords, input int abort_bits);
        logic [W-1:0] exp_tx;
        logic [W-1:0] got_tx;
        logic [W-1:0] mo;
        logic         lead;
        int           nb;
        int           rv_start;
        lead     = (d == 1) ? 1'b0 : 1'b1;
        rv_start = rv_cnt[d];
        cs_n[d]  = 1'b0;
        wait_clk(8);
        for (int w = 0; w <= nwords; w++) begin
            nb = (w == nwords) ? abort_bits : W;
            if (nb == 0) break;
            exp_tx = gen_word(d);
            mo     = (mo_q.size() > 0) ? mo_q.pop_front() : W'($urandom);
            got_tx = '0;
            for (int b = 0; b < nb; b++) begin
                mosi[d] = mo[W-1-b];
                wait_clk(HALF);
                got_tx[W-1-b] = miso[d];
                sck[d] = lead;
                wait_clk(HALF);
                sck[d] = ~lead;
            end
            wait_clk(HALF);
            if (nb == W) begin
                check("miso_word", got_tx, exp_tx);
                check("rx_word", rx_of(d), mo);
                check("rx_valid_pulses", rv_cnt[d] - rv_start, w + 1);
                m_rx[d]   = mo;
                m_cnt[d]  = (m_cnt[d] + 1) % cnt_mod[d];
                m_lfsr[d] = lfsr_next(m_lfsr[d]);
            end else begin
                check("miso_partial", got_tx >> (W - nb), exp_tx >> (W - nb));
            end
        end
        check("oe_active", oe[d], 1'b1);
        cs_n[d] = 1'b1;
        wait_clk(8);
        check("oe_release", oe[d], 1'b0);
        check("miso_release", miso[d], 1'b0);
        check("rx_valid_total", rv_cnt[d] - rv_start, nwords);
        check("word_cnt", wc_of(d), m_cnt[d]);
    endtask

    // CS rises in the same cycle as the leading edge of the last bit: the word must be dropped.
    task automatic cs_sck_collision();
        int rv_start;
        rv_start = rv_cnt[0];
        cs_n[0]  = 1'b0;
        wait_clk(8);
        for (int b = 0; b < W; b++) begin
            mosi[0] = 1'($urandom);
            wait_clk(HALF);
            if (b == W - 1) cs_n[0] = 1'b1;
            sck[0] = 1'b1;
            wait_clk(HALF);
            sck[0] = 1'b0;
        end
        wait_clk(8);
        check("collision_rx_valid", rv_cnt[0] - rv_start, 0);
        check("collision_word_cnt", wc_of(0), m_cnt[0]);
    endtask

    initial begin
        rst_n    = 1'b0;
        sck      = 2'b10;
        cs_n     = 2'b11;
        mosi     = 2'b00;
        psel[0]  = 2'd0;
        psel[1]  = 2'd0;
        cword[0] = '0;
        cword[1] = '0;
        model_reset();
        wait_clk(3);
        for (int d = 0; d < 2; d++) begin
            check("rst_miso", miso[d], 1'b0);
            check("rst_oe", oe[d], 1'b0);
            check("rst_rx_valid", rxv[d], 1'b0);
            check("rst_rx_word", rx_of(d), '0);
            check("rst_word_cnt", wc_of(d), 0);
        end
        rst_n = 1'b1;
        wait_clk(4);

        // LFSR from reset: 0x01, 0xB8, 0x5C
        psel[0] = 2'd1;
        xfer(0, 3, 0);

        // Counter from reset: 0x00, 0x01, 0x02
        do_reset();
        psel[0] = 2'd0;
        xfer(0, 3, 0);

        // Loopback: MOSI 0xA5, 0x3C -> MISO 0x00, 0xA5
        do_reset();
        psel[0] = 2'd3;
        mo_q.push_back(8'hA5);
        mo_q.push_back(8'h3C);
        xfer(0, 2, 0);

        // Abort after 5 bits of word 1, then a fresh transaction resends 0x01
        do_reset();
        psel[0] = 2'd0;
        xfer(0, 1, 5);
        xfer(0, 1, 0);

        // CPOL=1 instance, constant 0x96, MOSI sampled on falling edges
        psel[1]  = 2'd2;
        cword[1] = 8'h96;
        mo_q.push_back(8'h5A);
        mo_q.push_back(8'hC3);
        xfer(1, 2, 0);

        cs_sck_collision();

        // Asynchronous reset in the middle of a word
        psel[0]  = 2'd2;
        cword[0] = 8'hFF;
        cs_n[0]  = 1'b0;
        wait_clk(8);
        for (int b = 0; b < 3; b++) begin
            mosi[0] = 1'b1;
            wait_clk(HALF);
            sck[0] = 1'b1;
            wait_clk(HALF);
            sck[0] = 1'b0;
        end
        wait_clk(HALF);
        check("pre_rst_miso", miso[0], 1'b1);
        check("pre_rst_oe", oe[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_miso", miso[0], 1'b0);
        check("async_rst_oe", oe[0], 1'b0);
        check("async_rst_word_cnt", wc_of(0), 0);
        wait_clk(2);
        cs_n[0] = 1'b1;
        wait_clk(1);
        rst_n = 1'b1;
        model_reset();
        wait_clk(4);
        psel[0] = 2'd0;
        xfer(0, 2, 0);

        // Narrow counter on the CPOL=1 instance wraps 15 -> 0
        psel[1] = 2'd0;
        xfer(1, 18, 0);

        // Randomized traffic on both instances
        for (int t = 0; t < 24; t++) begin
            int d;
            int nw;
            int ab;
            d        = ($urandom_range(0, 3) == 0) ? 1 : 0;
            psel[d]  = 2'($urandom_range(0, 3));
            cword[d] = W'($urandom);
            nw       = $urandom_range(1, 3);
            ab       = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : 0;
            wait_clk(2);
            xfer(d, nw, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
